// File: rtl/imem_pkg.sv
// -----------------------------------------------------------------------------
// imem_pkg
// Shared definitions for the instruction-pair server: FSM state encoding,
// default fetch-address width and the instruction-pair / RAM word widths.
// No ports (package).
// -----------------------------------------------------------------------------
package imem_pkg;

  localparam int ADDR_W_DEF = 10;
  localparam int PAIR_W     = 64;
  localparam int WORD_W     = 32;

  // PF0/PF1 are only reachable when the prefetch entry is built in.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD0  = 3'd1,
    RD1  = 3'd2,
    PF0  = 3'd3,
    PF1  = 3'd4
  } state_e;

endpackage

// File: rtl/imem_pair_entry.sv
// -----------------------------------------------------------------------------
// imem_pair_entry
// One resident instruction pair: word-address tag, valid bit and 64-bit data,
// with a tag compare against the current fetch word address.
//
// Ports:
//   clock_i, reset_i     clock and synchronous active-high reset
//   inv_i                clear valid (start of a fill into this entry)
//   wr_hi_i / wr_lo_i    write word_i into data[63:32] / data[31:0]
//   commit_i             set tag to commit_tag_i and mark valid
//   load_i               write the whole entry (tag + data) in one cycle
//   cmp_tag_i            word address to compare against
//   hit_o                valid and tag matches cmp_tag_i
//   tag_o, valid_o       current tag / valid
//   data_o               current 64-bit pair
// -----------------------------------------------------------------------------
module imem_pair_entry
  import imem_pkg::*;
#(
  parameter int TAG_W = 8
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              inv_i,
  input  logic              wr_hi_i,
  input  logic              wr_lo_i,
  input  logic [WORD_W-1:0] word_i,
  input  logic              commit_i,
  input  logic [TAG_W-1:0]  commit_tag_i,
  input  logic              load_i,
  input  logic [TAG_W-1:0]  load_tag_i,
  input  logic [PAIR_W-1:0] load_data_i,
  input  logic [TAG_W-1:0]  cmp_tag_i,
  output logic              hit_o,
  output logic [TAG_W-1:0]  tag_o,
  output logic              valid_o,
  output logic [PAIR_W-1:0] data_o
);

  logic [TAG_W-1:0]  tag_q, tag_d;
  logic              valid_q, valid_d;
  logic [PAIR_W-1:0] data_q, data_d;

  // Next-state for tag/valid/data; a whole-entry load overrides piecewise fills.
  always_comb begin
    tag_d   = tag_q;
    valid_d = valid_q;
    data_d  = data_q;
    if (load_i) begin
      tag_d   = load_tag_i;
      valid_d = 1'b1;
      data_d  = load_data_i;
    end else begin
      if (inv_i) begin
        valid_d = 1'b0;
      end else begin
        valid_d = valid_q;
      end
      if (wr_hi_i) begin
        data_d[PAIR_W-1:WORD_W] = word_i;
      end else begin
        data_d[PAIR_W-1:WORD_W] = data_q[PAIR_W-1:WORD_W];
      end
      if (wr_lo_i) begin
        data_d[WORD_W-1:0] = word_i;
      end else begin
        data_d[WORD_W-1:0] = data_q[WORD_W-1:0];
      end
      if (commit_i) begin
        tag_d   = commit_tag_i;
        valid_d = 1'b1;
      end else begin
        tag_d   = tag_q;
      end
    end
  end

  // Entry storage register.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      tag_q   <= {TAG_W{1'b0}};
      valid_q <= 1'b0;
      data_q  <= {PAIR_W{1'b0}};
    end else begin
      tag_q   <= tag_d;
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign hit_o   = valid_q && (tag_q == cmp_tag_i);
  assign tag_o   = tag_q;
  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/imem_pair_server.sv
// -----------------------------------------------------------------------------
// imem_pair_server
// Responder for the F2 instruction fetch of the dual-issue pipeline. Returns
// the pair {word@iaddr, word@iaddr+4} assembled from two reads of a
// single-ported 32-bit instruction RAM with 1-cycle read latency, and holds
// stall_o high until the requested pair is resident.
//
// Optional feature: define IMEM_PREFETCH_EN to add a second entry that
// speculatively holds the next sequential pair (resident word address + 2).
//
// Ports:
//   clock_i      system clock
//   reset_i      synchronous active-high reset
//   iaddr_i      fetch byte address (bits [1:0] ignored)
//   idata_o      [63:32] word at iaddr, [31:0] word at iaddr+4
//   stall_o      high while idata_o is not valid for iaddr_i
//   mem_re_o     RAM read enable
//   mem_addr_o   RAM word address
//   mem_rdata_i  RAM read data, valid the cycle after mem_re_o
// -----------------------------------------------------------------------------
module imem_pair_server
  import imem_pkg::*;
#(
  parameter int                ADDR_W   = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic [ADDR_W-1:0] iaddr_i,
  output logic [PAIR_W-1:0] idata_o,
  output logic              stall_o,
  output logic              mem_re_o,
  output logic [ADDR_W-3:0] mem_addr_o,
  input  logic [WORD_W-1:0] mem_rdata_i
);

  localparam int              WA_W   = ADDR_W - 2;
  localparam logic [WA_W-1:0] WA_ONE = WA_W'(1);

  state_e            state_q, state_d;
  logic [WA_W-1:0]   fill_addr_q, fill_addr_d;
  logic [WA_W-1:0]   req_word;

  logic              m_hit, m_valid;
  logic [WA_W-1:0]   m_tag;
  logic [PAIR_W-1:0] m_data;
  logic              m_inv, m_wr_hi, m_wr_lo, m_commit, m_load;
  logic [WA_W-1:0]   m_load_tag;
  logic [PAIR_W-1:0] m_load_data;

  logic              mem_re;
  logic [WA_W-1:0]   mem_addr;
  logic              unused_s;

  assign req_word = iaddr_i[ADDR_W-1:2];

`ifdef IMEM_PREFETCH_EN
  localparam logic [WA_W-1:0] WA_TWO = WA_W'(2);

  logic              pf_hit, pf_valid, pf_next_ok;
  logic [WA_W-1:0]   pf_tag;
  logic [PAIR_W-1:0] pf_data;
  logic              pf_inv, pf_wr_hi, pf_wr_lo, pf_commit;

  // The pf entry is useful only if it holds the pair right after the main one.
  assign pf_next_ok  = pf_valid && (pf_tag == (m_tag + WA_TWO));
  assign m_load_tag  = pf_tag;
  assign m_load_data = pf_data;
  assign unused_s    = ^{iaddr_i[1:0], RESET_PC[1:0], m_valid};

  imem_pair_entry #(.TAG_W(WA_W)) u_pf_entry (
    .clock_i      (clock_i),
    .reset_i      (reset_i),
    .inv_i        (pf_inv),
    .wr_hi_i      (pf_wr_hi),
    .wr_lo_i      (pf_wr_lo),
    .word_i       (mem_rdata_i),
    .commit_i     (pf_commit),
    .commit_tag_i (fill_addr_q),
    .load_i       (1'b0),
    .load_tag_i   ({WA_W{1'b0}}),
    .load_data_i  ({PAIR_W{1'b0}}),
    .cmp_tag_i    (req_word),
    .hit_o        (pf_hit),
    .tag_o        (pf_tag),
    .valid_o      (pf_valid),
    .data_o       (pf_data)
  );

  // A prefetch in progress does not stall a fetch that already hits.
  assign stall_o = (state_q == RD0) || (state_q == RD1) || !m_hit;
`else
  assign m_load_tag  = {WA_W{1'b0}};
  assign m_load_data = {PAIR_W{1'b0}};
  assign unused_s    = ^{iaddr_i[1:0], RESET_PC[1:0], m_valid, m_tag};

  assign stall_o = (state_q != IDLE) || !m_hit;
`endif

  imem_pair_entry #(.TAG_W(WA_W)) u_main_entry (
    .clock_i      (clock_i),
    .reset_i      (reset_i),
    .inv_i        (m_inv),
    .wr_hi_i      (m_wr_hi),
    .wr_lo_i      (m_wr_lo),
    .word_i       (mem_rdata_i),
    .commit_i     (m_commit),
    .commit_tag_i (fill_addr_q),
    .load_i       (m_load),
    .load_tag_i   (m_load_tag),
    .load_data_i  (m_load_data),
    .cmp_tag_i    (req_word),
    .hit_o        (m_hit),
    .tag_o        (m_tag),
    .valid_o      (m_valid),
    .data_o       (m_data)
  );

  // Fill sequencer: next state, RAM request and entry write strobes.
  always_comb begin
    state_d     = state_q;
    fill_addr_d = fill_addr_q;
    m_inv       = 1'b0;
    m_wr_hi     = 1'b0;
    m_wr_lo     = 1'b0;
    m_commit    = 1'b0;
    m_load      = 1'b0;
    mem_re      = 1'b0;
    mem_addr    = {WA_W{1'b0}};
`ifdef IMEM_PREFETCH_EN
    pf_inv      = 1'b0;
    pf_wr_hi    = 1'b0;
    pf_wr_lo    = 1'b0;
    pf_commit   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (!m_hit) begin
`ifdef IMEM_PREFETCH_EN
          if (pf_hit) begin
            // Promote the prefetched pair; costs a single stall cycle.
            m_load = 1'b1;
            pf_inv = 1'b1;
          end else begin
            fill_addr_d = req_word;
            mem_re      = 1'b1;
            mem_addr    = req_word;
            m_inv       = 1'b1;
            state_d     = RD0;
          end
        end else begin
          if (!pf_next_ok) begin
            fill_addr_d = m_tag + WA_TWO;
            mem_re      = 1'b1;
            mem_addr    = m_tag + WA_TWO;
            pf_inv      = 1'b1;
            state_d     = PF0;
          end else begin
            state_d = IDLE;
          end
`else
          // First read of the pair is issued in the miss-detect cycle.
          fill_addr_d = req_word;
          mem_re      = 1'b1;
          mem_addr    = req_word;
          m_inv       = 1'b1;
          state_d     = RD0;
        end else begin
          state_d = IDLE;
`endif
        end
      end
      RD0: begin
        // Increment wraps modulo the word-address space.
        m_wr_hi  = 1'b1;
        mem_re   = 1'b1;
        mem_addr = fill_addr_q + WA_ONE;
        state_d  = RD1;
      end
      RD1: begin
        m_wr_lo  = 1'b1;
        m_commit = 1'b1;
        state_d  = IDLE;
      end
`ifdef IMEM_PREFETCH_EN
      PF0: begin
        pf_wr_hi = 1'b1;
        mem_re   = 1'b1;
        mem_addr = fill_addr_q + WA_ONE;
        state_d  = PF1;
      end
      PF1: begin
        pf_wr_lo  = 1'b1;
        pf_commit = 1'b1;
        state_d   = IDLE;
      end
`endif
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Sequencer state and fill address registers.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      fill_addr_q <= RESET_PC[ADDR_W-1:2];
    end else begin
      state_q     <= state_d;
      fill_addr_q <= fill_addr_d;
    end
  end

  // RAM request is held at its reset value while reset is asserted.
  assign mem_re_o   = mem_re & ~reset_i;
  assign mem_addr_o = reset_i ? {WA_W{1'b0}} : mem_addr;
  assign idata_o    = m_data;

endmodule

// File: tb/tb_imem_pair_server.sv
// -----------------------------------------------------------------------------
// tb_imem_pair_server
// Directed bench for imem_pair_server with a behavioural 1-cycle-latency RAM.
// Inputs change and outputs are sampled just after the falling clock edge.
// -----------------------------------------------------------------------------
module tb_imem_pair_server;

  logic        clock_i = 1'b0;
  logic        reset_i;
  logic [9:0]  iaddr_i;
  logic [63:0] idata_o;
  logic        stall_o;
  logic        mem_re_o;
  logic [7:0]  mem_addr_o;
  logic [31:0] mem_rdata_i = 32'h0000_0000;

  logic [31:0] ram [256];

  int checks = 0;
  int errors = 0;

  imem_pair_server dut (
    .clock_i     (clock_i),
    .reset_i     (reset_i),
    .iaddr_i     (iaddr_i),
    .idata_o     (idata_o),
    .stall_o     (stall_o),
    .mem_re_o    (mem_re_o),
    .mem_addr_o  (mem_addr_o),
    .mem_rdata_i (mem_rdata_i)
  );

  always #5 clock_i = ~clock_i;

  // Instruction RAM model: registered read, one cycle latency.
  always @(posedge clock_i) begin
    if (mem_re_o) mem_rdata_i <= ram[mem_addr_o];
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clock_i);
    #1;
  endtask

  // Starts in the miss-detect cycle; ends in the first cycle with the pair resident.
  task automatic expect_fill(input string tag, input logic [7:0] w, input logic [63:0] pair);
    logic [7:0] w1;
    w1 = w + 8'd1;
    check_eq({tag, "_a_stall"}, 64'(stall_o), 64'd1);
    check_eq({tag, "_a_re"}, 64'(mem_re_o), 64'd1);
    check_eq({tag, "_a_addr"}, 64'(mem_addr_o), 64'(w));
    step();
    check_eq({tag, "_b_stall"}, 64'(stall_o), 64'd1);
    check_eq({tag, "_b_re"}, 64'(mem_re_o), 64'd1);
    check_eq({tag, "_b_addr"}, 64'(mem_addr_o), 64'(w1));
    step();
    check_eq({tag, "_c_stall"}, 64'(stall_o), 64'd1);
    check_eq({tag, "_c_re"}, 64'(mem_re_o), 64'd0);
    step();
    check_eq({tag, "_d_stall"}, 64'(stall_o), 64'd0);
    check_eq({tag, "_d_data"}, idata_o, pair);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 32'hC0DE_0000 | 32'(i);
    ram[0]   = 32'h1111_1111;
    ram[1]   = 32'h2222_2222;
    ram[2]   = 32'h3333_3333;
    ram[3]   = 32'h4444_4444;
    ram[4]   = 32'h5555_5555;
    ram[255] = 32'hAAAA_AAAA;

    // Reset state.
    reset_i = 1'b1;
    iaddr_i = 10'h000;
    repeat (2) @(posedge clock_i);
    step();
    check_eq("rst_data", idata_o, 64'h0);
    check_eq("rst_re", 64'(mem_re_o), 64'd0);
    check_eq("rst_addr", 64'(mem_addr_o), 64'd0);
    check_eq("rst_stall", 64'(stall_o), 64'd1);

    // First fill after reset release.
    reset_i = 1'b0;
    #1;
    expect_fill("boot", 8'h00, 64'h1111_1111_2222_2222);

    // Steady hit.
    for (int i = 0; i < 10; i++) begin
      check_eq("hit_stall", 64'(stall_o), 64'd0);
`ifndef IMEM_PREFETCH_EN
      check_eq("hit_re", 64'(mem_re_o), 64'd0);
`endif
      check_eq("hit_data", idata_o, 64'h1111_1111_2222_2222);
      step();
    end

    // Misaligned pair.
    iaddr_i = 10'h004;
    #1;
    expect_fill("misal", 8'h01, 64'h2222_2222_3333_3333);

    // Wrap-around from word 0xFF to word 0x00.
    iaddr_i = 10'h3FC;
    #1;
    expect_fill("wrap", 8'hFF, 64'hAAAA_AAAA_1111_1111);

    // Reset pulsed while in RD0.
    iaddr_i = 10'h008;
    #1;
    check_eq("rmid_a_re", 64'(mem_re_o), 64'd1);
    check_eq("rmid_a_addr", 64'(mem_addr_o), 64'd2);
    step();
    reset_i = 1'b1;
    #1;
    check_eq("rmid_re", 64'(mem_re_o), 64'd0);
    step();
    check_eq("rmid_data", idata_o, 64'h0);
    check_eq("rmid_stall", 64'(stall_o), 64'd1);
    reset_i = 1'b0;
    #1;
    expect_fill("refill", 8'h02, 64'h3333_3333_4444_4444);

    // Address change mid-fill: the fill completes for the latched address.
    iaddr_i = 10'h000;
    #1;
    check_eq("chg_a_addr", 64'(mem_addr_o), 64'd0);
    step();
    iaddr_i = 10'h00C;
    #1;
    check_eq("chg_b_re", 64'(mem_re_o), 64'd1);
    check_eq("chg_b_addr", 64'(mem_addr_o), 64'd1);
    step();
    check_eq("chg_c_stall", 64'(stall_o), 64'd1);
    step();
    check_eq("chg_d_data", idata_o, 64'h1111_1111_2222_2222);
    check_eq("chg_d_stall", 64'(stall_o), 64'd1);
    expect_fill("chg_next", 8'h03, 64'h4444_4444_5555_5555);

`ifdef IMEM_PREFETCH_EN
    // Sequential fetch served from the prefetch entry.
    iaddr_i = 10'h000;
    #1;
    expect_fill("pf_base", 8'h00, 64'h1111_1111_2222_2222);
    repeat (4) step();
    iaddr_i = 10'h008;
    #1;
    check_eq("pf_stall1", 64'(stall_o), 64'd1);
    step();
    check_eq("pf_stall2", 64'(stall_o), 64'd0);
    check_eq("pf_data", idata_o, 64'h3333_3333_4444_4444);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
